rmii_rx_framer: RTL and testbench
=================================

// Module: rmii_rx_framer
// PURPOSE
//  RMII 100 Mb/s receive front-end. Feeds the Ethernet RX path inside peripherals.
//  Samples the 2-bit RMII RX bus, strips preamble/SFD and assembles bytes LSB-first.
//  Emits a byte stream with last/error markers; checks FCS and frame length, keeps stats.
//  No backpressure: RMII cannot be stalled, so the consumer must accept every m_valid beat.
// PARAMETERS
//  MIN_LEN    64    minimum legal frame length in bytes (DA..FCS inclusive)
//  MAX_LEN    1518  maximum legal frame length in bytes (DA..FCS inclusive)
//  CHECK_CRC  1     1: FCS mismatch sets m_err; 0: FCS is not checked
// PORTS
//  clk          in   1   50 MHz RMII reference clock; one dibit is sampled every cycle
//  reset        in   1   asynchronous, active-high
//  rmii_crs_dv  in   1   RMII carrier-sense/data-valid (already synchronous to clk)
//  rmii_rxd     in   2   RMII receive dibit, bit 0 first on the wire
//  m_valid      out  1   one-cycle byte strobe
//  m_data       out  8   received byte, DA..FCS; FCS bytes are passed through
//  m_last       out  1   qualifies the final byte of the frame
//  m_err        out  1   frame bad; meaningful only when m_valid & m_last
//  busy         out  1   high when state != IDLE
//  frame_cnt    out  16  count of good frames, wraps at 0xFFFF
//  err_cnt      out  16  count of bad frames, wraps at 0xFFFF
// BEHAVIOUR
//  Reset
//   All outputs go to 0; state=IDLE. crs_q (registered crs_dv) resets to 1.
//  States
//   IDLE -> PREAMBLE: crs_dv 0->1 edge (crs_dv=1, crs_q=0) with rxd=01.
//    A frame already in progress when reset releases is therefore ignored.
//   PREAMBLE: rxd=01 stays. rxd=11 (SFD tail) -> DATA, dibit/byte counters cleared.
//    crs_dv=0 -> IDLE. Any other dibit -> DROP.
//   DATA: shift in {rxd,sr[7:2]}. Every 4th dibit completes a byte and updates CRC/len.
//    crs_dv=0 -> END.
//   DROP: wait for crs_dv=0 -> IDLE. No output and no counter change.
//   END: one cycle; emits the held byte with m_last, updates the counters -> IDLE.
//  Output timing
//   A completed byte is held in a pending register.
//   The held byte is emitted (m_valid=1 for 1 cycle) when the next byte completes,
//    so m_valid beats are spaced exactly 4 cycles apart.
//   Final byte: m_valid&m_last occur in the cycle after crs_dv is first sampled 0.
//   m_data/m_last/m_err are registered and hold their value between strobes.
//   m_last and m_err are 0 whenever m_valid=0.
//  Error rules: m_err = any of the following.
//   FCS bad (CHECK_CRC=1): CRC32 (poly 04C11DB7, init FFFFFFFF, reflected) run over
//    DA..FCS; the residue must equal 0xC704DD7B.
//   len < MIN_LEN or len > MAX_LEN. The byte counter saturates at MAX_LEN+1.
//   Misaligned end: dibit count mod 4 != 0 when crs_dv drops. The partial byte is discarded.
//   Bytes beyond MAX_LEN are still forwarded. The error is flagged only on the final byte.
//  Zero complete bytes after SFD:
//   No m_valid. err_cnt increments, frame_cnt does not.
//  Counter update: end of each frame that reached DATA.
//   frame_cnt increments if !err, otherwise err_cnt increments.
//  Simultaneous events:
//   crs_dv=0 on the same cycle a byte would complete means that byte is NOT complete.
//   The end takes priority and the frame is treated as a misaligned end.
//  Reset mid-frame: outputs are cleared immediately. The partial frame is not counted.
// TESTING
//  1. 7x55,D5 + 64B frame with correct FCS -> 64 beats, 4 cycles apart.
//     Last beat m_last=1, m_err=0; frame_cnt=1, err_cnt=0.
//  2. Same frame with one payload bit flipped -> 64 beats; final beat m_err=1; err_cnt=1.
//  3. 60B frame with valid FCS -> final beat m_err=1 (short). 1519B frame -> m_err=1.
//  4. crs_dv drops 2 dibits into byte 65 -> 64 beats, last beat has m_last=1, m_err=1.
//  5. reset pulsed mid-frame, released with crs_dv=1 -> m_valid stays 0 until crs_dv low.
//     The next good frame is then received normally; frame_cnt=1.
//  6. Preamble containing dibit 10 -> DROP; no beats; both counters unchanged.
//     busy falls when crs_dv=0.

Source files
------------

// File: rtl/rmii_rx_framer.sv
// RMII 100 Mb/s receive framer: strips preamble/SFD, assembles bytes LSB-first,
// streams them out one byte behind the wire, and flags bad frames on the last byte.
module rmii_rx_framer #(
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rmii_crs_dv,
    input  logic [1:0]  rmii_rxd,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        m_err,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    // Byte counter must hold MAX_LEN+1, where it saturates.
    localparam int LW = $clog2(MAX_LEN + 2);

    // Good-FCS residue, written in wire (non-reflected) bit order.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP,
        S_END
    } state_t;

    state_t          state;
    logic            crs_q;
    logic [5:0]      sr;          // previous three dibits of the byte in progress
    logic [1:0]      dibit_cnt;
    logic [LW-1:0]   len;
    logic [31:0]     crc;
    logic [7:0]      pend;        // completed byte waiting to be emitted
    logic            pend_vld;
    logic [7:0]      new_byte;
    logic            frame_bad;

    // One byte of reflected CRC-32 (poly 04C11DB7, LSB-first).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    assign new_byte = {rmii_rxd, sr};
    assign busy     = (state != S_IDLE);

    // Frame verdict, evaluated while in S_END using the final CRC/length/alignment.
    // NOTE: every combinational output gets a value on every path so no latch is inferred.
    always_comb begin
        frame_bad = 1'b0;
        if (CHECK_CRC && (bit_rev32(crc) != CRC_RESIDUE)) frame_bad = 1'b1;
        if (len < LW'(MIN_LEN))                          frame_bad = 1'b1;
        if (len > LW'(MAX_LEN))                          frame_bad = 1'b1;
        if (dibit_cnt != 2'd0)                           frame_bad = 1'b1;
    end

    // Receive FSM with registered stream outputs and statistics counters.
    // NOTE: all state here uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            crs_q     <= 1'b1;      // a carrier already up at release is not an edge
            sr        <= '0;
            dibit_cnt <= '0;
            len       <= '0;
            crc       <= '1;
            pend      <= '0;
            pend_vld  <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            m_err     <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            crs_q   <= rmii_crs_dv;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rmii_crs_dv && !crs_q && rmii_rxd == 2'b01) state <= S_PREAMBLE;
                end

                S_PREAMBLE: begin
                    if (!rmii_crs_dv) begin
                        state <= S_IDLE;
                    end else if (rmii_rxd == 2'b11) begin
                        state     <= S_DATA;
                        dibit_cnt <= '0;
                        len       <= '0;
                        crc       <= '1;
                        pend_vld  <= 1'b0;
                    end else if (rmii_rxd != 2'b01) begin
                        state <= S_DROP;
                    end
                end

                S_DATA: begin
                    // Carrier loss wins over a byte completing on the same dibit.
                    if (!rmii_crs_dv) begin
                        state <= S_END;
                    end else begin
                        sr        <= new_byte[7:2];
                        dibit_cnt <= dibit_cnt + 2'd1;
                        if (dibit_cnt == 2'd3) begin
                            if (pend_vld) begin
                                m_valid <= 1'b1;
                                m_data  <= pend;
                            end
                            pend     <= new_byte;
                            pend_vld <= 1'b1;
                            crc      <= crc_byte(crc, new_byte);
                            if (len <= LW'(MAX_LEN)) len <= len + LW'(1);
                        end
                    end
                end

                S_DROP: begin
                    if (!rmii_crs_dv) state <= S_IDLE;
                end

                S_END: begin
                    if (pend_vld) begin
                        m_valid <= 1'b1;
                        m_data  <= pend;
                        m_last  <= 1'b1;
                        m_err   <= frame_bad;
                    end
                    if (frame_bad) err_cnt   <= err_cnt + 16'd1;
                    else           frame_cnt <= frame_cnt + 16'd1;
                    pend_vld <= 1'b0;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: drives RMII dibits, records output beats,
// and checks beats, markers, spacing and counters against hand-built frames.
module tb_rmii_rx_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rmii_crs_dv;
    logic [1:0]  rmii_rxd;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_err;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    rmii_rx_framer dut (
        .clk         (clk),
        .reset       (reset),
        .rmii_crs_dv (rmii_crs_dv),
        .rmii_rxd    (rmii_rxd),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_err       (m_err),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #10 clk = ~clk;

    // Beat recorder
    int         cyc = 0;
    logic [7:0] bd[$];
    bit         bl[$];
    bit         be[$];
    int         bc[$];
    int         stray = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid) begin
            bd.push_back(m_data);
            bl.push_back(m_last);
            be.push_back(m_err);
            bc.push_back(cyc);
        end else if (m_last || m_err) begin
            stray++;
        end
    end

    // Frame builder and driver
    logic [7:0] frame[$];
    int         dib_idx;
    int         rst_at = -1;

    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic build_frame(input int total);
        logic [31:0] c;
        logic [31:0] fcs;
        frame.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < total - 4; i++) begin
            frame.push_back(8'((i * 7 + 3) & 8'hFF));
            c = ref_crc(c, frame[i]);
        end
        fcs = ~c;
        for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
    endtask

    task automatic clear_beats();
        bd.delete(); bl.delete(); be.delete(); bc.delete();
    endtask

    task automatic drive_dibit(input logic dv, input logic [1:0] d);
        @(negedge clk);
        if (dib_idx == rst_at)     reset = 1'b1;
        if (dib_idx == rst_at + 2) begin
            reset = 1'b0;
            clear_beats();
        end
        rmii_crs_dv = dv;
        rmii_rxd    = d;
        dib_idx++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_dibit(1'b0, 2'b00);
    endtask

    // 7x55 + D5 preamble, the frame bytes, optional trailing partial dibits.
    task automatic drive_frame(input int n_extra);
        logic [7:0] b;
        dib_idx = 0;
        for (int p = 0; p < 32; p++) drive_dibit(1'b1, (p == 31) ? 2'b11 : 2'b01);
        foreach (frame[i]) begin
            b = frame[i];
            for (int k = 0; k < 4; k++) drive_dibit(1'b1, b[2*k +: 2]);
        end
        for (int k = 0; k < n_extra; k++) drive_dibit(1'b1, 2'b10);
        idle(8);
    endtask

    task automatic check_beats(input string name, input int exp_n, input bit exp_err,
                               input int exp_gap);
        int bad_data;
        int bad_last;
        int bad_gap;
        checks++;
        if (bd.size() !== exp_n) begin
            failures++;
            $display("FAIL %s beat_count got=%0d exp=%0d", name, bd.size(), exp_n);
        end
        if (exp_n == 0 || bd.size() != exp_n) return;
        bad_data = 0; bad_last = 0; bad_gap = 0;
        for (int i = 0; i < exp_n; i++) begin
            if (bd[i] !== frame[i]) bad_data++;
            if (bl[i] !== (i == exp_n - 1)) bad_last++;
            if (i > 0 && i < exp_n - 1 && bc[i] - bc[i-1] != 4) bad_gap++;
        end
        checks++;
        if (bad_data != 0) begin
            failures++;
            $display("FAIL %s data_mismatches got=%0d exp=0", name, bad_data);
        end
        checks++;
        if (bad_last != 0) begin
            failures++;
            $display("FAIL %s last_marker_errors got=%0d exp=0", name, bad_last);
        end
        checks++;
        if (bad_gap != 0) begin
            failures++;
            $display("FAIL %s beat_spacing_errors got=%0d exp=0", name, bad_gap);
        end
        checks++;
        if (be[exp_n-1] !== exp_err) begin
            failures++;
            $display("FAIL %s final_err got=%0b exp=%0b", name, be[exp_n-1], exp_err);
        end
        if (exp_gap > 0 && exp_n > 1) begin
            checks++;
            if (bc[exp_n-1] - bc[exp_n-2] != exp_gap) begin
                failures++;
                $display("FAIL %s last_gap got=%0d exp=%0d", name,
                         bc[exp_n-1] - bc[exp_n-2], exp_gap);
            end
        end
    endtask

    task automatic check_counts(input string name, input int fc, input int ec);
        checks++;
        if (frame_cnt !== 16'(fc) || err_cnt !== 16'(ec)) begin
            failures++;
            $display("FAIL %s counters got=%0d/%0d exp=%0d/%0d", name, frame_cnt, err_cnt, fc, ec);
        end
    endtask

    // Tests
    task automatic test_reset();
        reset = 1'b1; rmii_crs_dv = 1'b0; rmii_rxd = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last, m_err, busy, frame_cnt, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset outputs got=%0h exp=0",
                     {m_valid, m_data, m_last, m_err, busy, frame_cnt, err_cnt});
        end
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_good_frame();
        build_frame(64); clear_beats();
        drive_frame(0);
        check_beats("good64", 64, 1'b0, 2);
        check_counts("good64", 1, 0);
    endtask

    task automatic test_bad_fcs();
        build_frame(64);
        frame[20] = frame[20] ^ 8'h10;
        clear_beats();
        drive_frame(0);
        check_beats("badfcs", 64, 1'b1, 2);
        check_counts("badfcs", 1, 1);
    endtask

    task automatic test_length();
        build_frame(60); clear_beats();
        drive_frame(0);
        check_beats("short60", 60, 1'b1, 2);
        check_counts("short60", 1, 2);
        build_frame(1519); clear_beats();
        drive_frame(0);
        check_beats("long1519", 1519, 1'b1, 2);
        check_counts("long1519", 1, 3);
    endtask

    task automatic test_misaligned();
        build_frame(64); clear_beats();
        drive_frame(2);
        check_beats("misalign", 64, 1'b1, 4);
        check_counts("misalign", 1, 4);
    endtask

    task automatic test_zero_bytes();
        frame.delete(); clear_beats();
        drive_frame(0);
        check_beats("zero", 0, 1'b0, 0);
        check_counts("zero", 1, 5);
    endtask

    task automatic test_drop();
        clear_beats();
        dib_idx = 0;
        for (int i = 0; i < 5; i++)  drive_dibit(1'b1, 2'b01);
        drive_dibit(1'b1, 2'b10);
        for (int i = 0; i < 26; i++) drive_dibit(1'b1, (i == 25) ? 2'b11 : 2'b01);
        for (int i = 0; i < 40; i++) drive_dibit(1'b1, 2'(i));
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL drop busy_in_drop got=%0b exp=1", busy);
        end
        idle(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drop busy_after got=%0b exp=0", busy);
        end
        idle(6);
        check_beats("drop", 0, 1'b0, 0);
        check_counts("drop", 1, 5);
    endtask

    task automatic test_reset_mid_frame();
        build_frame(64); clear_beats();
        rst_at = 100;
        drive_frame(0);
        rst_at = -1;
        check_beats("rst_mid", 0, 1'b0, 0);
        check_counts("rst_mid", 0, 0);
        clear_beats();
        drive_frame(0);
        check_beats("after_rst", 64, 1'b0, 2);
        check_counts("after_rst", 1, 0);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_length();
        test_misaligned();
        test_zero_bytes();
        test_drop();
        test_reset_mid_frame();
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL markers_without_valid got=%0d exp=0", stray);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
